// File: rtl/mem_arbiter_if.sv
// Bundle between the request unit, mem_arbiter and the shared RAM port.
// master = the arbiter's view; slave = the requester/RAM environment view.
interface mem_arbiter_if;
  // Request side
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  // Statistics
  logic [31:0] icount;
  logic [31:0] dcount;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           icount, dcount
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           icount, dcount
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction/data requests onto one RAM port, data first.
// Optional completion counters are built only when MEM_ARB_STATS_EN is defined.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus,
  output logic [1:0]    o_state,
  output logic          o_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic       OWN_D      = 1'b0;
  localparam logic       OWN_I      = 1'b1;

  state_t      r_state;
  logic        r_owner;
  logic        r_ren;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic [31:0] r_iload;
  logic [31:0] r_dload;

  logic        w_dreq;
  logic        w_done_i;
  logic        w_done_d;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_done_i = (r_state == DONE) && (r_owner == OWN_I);
  assign w_done_d = (r_state == DONE) && (r_owner == OWN_D);

  // The RAM only ever sees the latched copy, so the requester may wiggle its
  // inputs while a transaction is in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_owner <= OWN_D;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq) begin
            r_owner <= OWN_D;
            r_addr  <= bus.daddr;
            r_store <= bus.dstore;
            r_ren   <= bus.dREN;
            r_wen   <= bus.dWEN;
            r_state <= DREQ;
          end else if (bus.iREN) begin
            r_owner <= OWN_I;
            r_addr  <= bus.iaddr;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_state <= IREQ;
          end
        end
        DREQ, IREQ: begin
          if (bus.ramstate == RAM_ACCESS) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= DONE;
            if (r_ren) begin
              if (r_owner == OWN_I) r_iload <= bus.ramload;
              else                  r_dload <= bus.ramload;
            end
          end else if (bus.ramstate == RAM_ERROR) begin
            // Abort; IDLE re-arbitrates and so retries the still-held request.
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= IDLE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.iwait    = bus.iREN & ~w_done_i;
  assign bus.dwait    = w_dreq & ~w_done_d;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.ramREN   = r_ren;
  assign bus.ramWEN   = r_wen;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;

  assign o_state = r_state;
  assign o_owner = r_owner;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_icount <= '0;
      r_dcount <= '0;
    end else begin
      if (w_done_i) r_icount <= r_icount + 32'd1;
      if (w_done_d) r_dcount <= r_dcount + 32'd1;
    end
  end

  assign bus.icount = r_icount;
  assign bus.dcount = r_dcount;
`else
  assign bus.icount = '0;
  assign bus.dcount = '0;
`endif

endmodule
